// File: rtl/axis_video_sink_monitor.sv
// AXI4-Stream video sink: consumes beats with optional throttled ready,
// measures line/frame geometry, checks SOF/EOL framing, signs frames.
//
// Ports:
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   s_axis_video_*          AXI4-Stream video slave (TKEEP/TSTRB/TID/TDEST unused)
//   throttle_en/pattern     ready pattern, one bit per 3-bit phase, LSB first
//   cfg_width_beats         expected beats per line (0 disables width checks)
//   clr_err                 pulse clearing the sticky error flags
//   frame_count             accepted SOFs (saturating)
//   last_line_beats         beats in most recent completed line
//   last_frame_lines        lines in most recent completed frame
//   frame_xor               XOR signature of most recent completed frame
//   err_eol_early/late      line width violations (sticky)
//   err_sof_mid             SOF inside a partial line (sticky)
module axis_video_sink_monitor #(
  parameter int NUM_VIDEO_COMPONENTS = 3,
  parameter int SAMPLES_PER_CLOCK    = 1,
  parameter int MAXIMUM_DATA_WIDTH   = 8,
  parameter int CNT_WIDTH            = 16,
  localparam int S_AXIS_BYTES =
    (SAMPLES_PER_CLOCK*MAXIMUM_DATA_WIDTH*NUM_VIDEO_COMPONENTS+7)/8,
  localparam int S_AXIS_WIDTH = S_AXIS_BYTES*8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [S_AXIS_WIDTH-1:0] s_axis_video_TDATA,
  input  logic                    s_axis_video_TVALID,
  output logic                    s_axis_video_TREADY,
  input  logic [S_AXIS_BYTES-1:0] s_axis_video_TKEEP,
  input  logic [S_AXIS_BYTES-1:0] s_axis_video_TSTRB,
  input  logic                    s_axis_video_TUSER,
  input  logic                    s_axis_video_TLAST,
  input  logic                    s_axis_video_TID,
  input  logic                    s_axis_video_TDEST,
  input  logic                    throttle_en,
  input  logic [7:0]              throttle_pattern,
  input  logic [CNT_WIDTH-1:0]    cfg_width_beats,
  input  logic                    clr_err,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    last_line_beats,
  output logic [CNT_WIDTH-1:0]    last_frame_lines,
  output logic [S_AXIS_WIDTH-1:0] frame_xor,
  output logic                    err_eol_early,
  output logic                    err_eol_late,
  output logic                    err_sof_mid
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic unused_ok;
  assign unused_ok = ^{s_axis_video_TKEEP, s_axis_video_TSTRB,
                       s_axis_video_TID, s_axis_video_TDEST};

  logic [2:0]              phase;
  logic                    tready_q;
  logic [CNT_WIDTH-1:0]    beat_cnt;
  logic [CNT_WIDTH-1:0]    line_cnt;
  logic [S_AXIS_WIDTH-1:0] xor_acc;
  logic                    in_frame;

  logic                    acc;
  logic                    sof;
  logic                    eol;
  logic                    chk_en;
  logic [CNT_WIDTH-1:0]    n;
  logic [CNT_WIDTH-1:0]    line_base;
  logic                    ev_early;
  logic                    ev_late;
  logic                    ev_sof;

  assign s_axis_video_TREADY = tready_q;

  always_comb begin
    acc       = s_axis_video_TVALID & tready_q;
    sof       = s_axis_video_TUSER;
    eol       = s_axis_video_TLAST;
    chk_en    = (cfg_width_beats != CNT_ZERO);
    n         = sof ? CNT_ONE : sat_inc(beat_cnt);
    // SOF restarts the line count before this beat's EOL is added
    line_base = sof ? CNT_ZERO : line_cnt;
    ev_early  = acc & eol & chk_en & (n < cfg_width_beats);
    // n passes cfg exactly once per line, so this fires once
    ev_late   = acc & ~eol & chk_en & (n == cfg_width_beats);
    ev_sof    = acc & sof & (beat_cnt != CNT_ZERO);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      phase            <= '0;
      tready_q         <= 1'b0;
      beat_cnt         <= '0;
      line_cnt         <= '0;
      xor_acc          <= '0;
      in_frame         <= 1'b0;
      frame_count      <= '0;
      last_line_beats  <= '0;
      last_frame_lines <= '0;
      frame_xor        <= '0;
      err_eol_early    <= 1'b0;
      err_eol_late     <= 1'b0;
      err_sof_mid      <= 1'b0;
    end else begin
      phase    <= phase + 3'd1;
      tready_q <= throttle_en ? throttle_pattern[phase] : 1'b1;

      // a new event wins over a coincident clear
      err_eol_early <= (err_eol_early & ~clr_err) | ev_early;
      err_eol_late  <= (err_eol_late & ~clr_err) | ev_late;
      err_sof_mid   <= (err_sof_mid & ~clr_err) | ev_sof;

      if (acc) begin
        if (sof) begin
          if (in_frame) begin
            last_frame_lines <= line_cnt;
            frame_xor        <= xor_acc;
          end
          xor_acc     <= s_axis_video_TDATA;
          in_frame    <= 1'b1;
          frame_count <= sat_inc(frame_count);
        end else begin
          xor_acc <= xor_acc ^ s_axis_video_TDATA;
        end

        // line count is frame-scoped; ignore lines before first SOF
        if (sof || in_frame) begin
          line_cnt <= eol ? sat_inc(line_base) : line_base;
        end

        if (eol) begin
          last_line_beats <= n;
          beat_cnt        <= '0;
        end else begin
          beat_cnt <= n;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_video_sink_monitor.sv
// Randomised + directed bench for axis_video_sink_monitor.
// Reference model tracks frames as queues of beats.
module tb_axis_video_sink_monitor;

  localparam int W = 24;
  localparam int B = 3;
  localparam int MAXV = 65535;
  localparam int MAX4 = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  tdata = '0;
  logic          tvalid = 1'b0;
  logic          tuser = 1'b0;
  logic          tlast = 1'b0;
  logic          ten = 1'b0;
  logic [7:0]    tpat = 8'h00;
  logic [15:0]   cfg = 16'd0;
  logic          clr = 1'b0;
  logic [3:0]    cfg4 = 4'd0;

  logic          tready;
  logic [15:0]   fc, llb, lfl;
  logic [W-1:0]  fxor;
  logic          e_early, e_late, e_sof;

  logic          tready4;
  logic [3:0]    fc4, llb4, lfl4;
  logic [W-1:0]  fxor4;
  logic          e_early4, e_late4, e_sof4;

  always #5 clk = ~clk;

  axis_video_sink_monitor dut (
    .ap_clk              (clk),
    .ap_rst_n            (rst_n),
    .s_axis_video_TDATA  (tdata),
    .s_axis_video_TVALID (tvalid),
    .s_axis_video_TREADY (tready),
    .s_axis_video_TKEEP  ({B{1'b1}}),
    .s_axis_video_TSTRB  ({B{1'b1}}),
    .s_axis_video_TUSER  (tuser),
    .s_axis_video_TLAST  (tlast),
    .s_axis_video_TID    (1'b0),
    .s_axis_video_TDEST  (1'b0),
    .throttle_en         (ten),
    .throttle_pattern    (tpat),
    .cfg_width_beats     (cfg),
    .clr_err             (clr),
    .frame_count         (fc),
    .last_line_beats     (llb),
    .last_frame_lines    (lfl),
    .frame_xor           (fxor),
    .err_eol_early       (e_early),
    .err_eol_late        (e_late),
    .err_sof_mid         (e_sof)
  );

  axis_video_sink_monitor #(.CNT_WIDTH(4)) dut4 (
    .ap_clk              (clk),
    .ap_rst_n            (rst_n),
    .s_axis_video_TDATA  (tdata),
    .s_axis_video_TVALID (tvalid),
    .s_axis_video_TREADY (tready4),
    .s_axis_video_TKEEP  ({B{1'b1}}),
    .s_axis_video_TSTRB  ({B{1'b1}}),
    .s_axis_video_TUSER  (tuser),
    .s_axis_video_TLAST  (tlast),
    .s_axis_video_TID    (1'b0),
    .s_axis_video_TDEST  (1'b0),
    .throttle_en         (ten),
    .throttle_pattern    (tpat),
    .cfg_width_beats     (cfg4),
    .clr_err             (clr),
    .frame_count         (fc4),
    .last_line_beats     (llb4),
    .last_frame_lines    (lfl4),
    .frame_xor           (fxor4),
    .err_eol_early       (e_early4),
    .err_eol_late        (e_late4),
    .err_sof_mid         (e_sof4)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  int           m_phase, m_fc, m_llb, m_lfl, m_lines, m_beats;
  bit           m_ready, m_in, m_acc;
  bit           m_ee, m_el, m_es;
  logic [W-1:0] m_fxor;
  logic [W-1:0] frame_q[$];

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [W-1:0] q_xor();
    logic [W-1:0] x = '0;
    foreach (frame_q[i]) x ^= frame_q[i];
    return x;
  endfunction

  task automatic model_step();
    int n;
    bit ee, el, es;
    ee = 0; el = 0; es = 0;
    m_acc = 0;
    if (!rst_n) begin
      m_phase = 0; m_ready = 0; m_fc = 0; m_llb = 0; m_lfl = 0;
      m_lines = 0; m_beats = 0; m_in = 0; m_fxor = '0;
      m_ee = 0; m_el = 0; m_es = 0;
      frame_q.delete();
      return;
    end
    m_acc = tvalid && m_ready;
    if (m_acc) begin
      n = tuser ? 1 : m_beats + 1;
      if (tuser) begin
        if (m_in) begin
          m_lfl  = m_lines;
          m_fxor = q_xor();
        end
        if (m_beats != 0) es = 1;
        frame_q.delete();
        m_lines = 0;
        m_in = 1;
        m_fc++;
      end
      frame_q.push_back(tdata);
      if (tlast) begin
        m_llb = n;
        m_beats = 0;
        if (m_in) m_lines++;
        if (cfg != 0 && n < int'(cfg)) ee = 1;
      end else begin
        m_beats = n;
        if (cfg != 0 && n == int'(cfg)) el = 1;
      end
    end
    m_ee = (m_ee && !clr) || ee;
    m_el = (m_el && !clr) || el;
    m_es = (m_es && !clr) || es;
    m_ready = ten ? tpat[m_phase] : 1'b1;
    m_phase = (m_phase + 1) % 8;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("tready", tready, m_ready);
    chk("frame_count", fc, clampv(m_fc, MAXV));
    chk("last_line_beats", llb, clampv(m_llb, MAXV));
    chk("last_frame_lines", lfl, clampv(m_lfl, MAXV));
    chk("frame_xor", fxor, m_fxor);
    chk("err_eol_early", e_early, m_ee);
    chk("err_eol_late", e_late, m_el);
    chk("err_sof_mid", e_sof, m_es);
    chk("frame_count4", fc4, clampv(m_fc, MAX4));
  endtask

  task automatic send(input logic [W-1:0] d, input bit u, input bit l);
    int k = 0;
    tvalid = 1; tdata = d; tuser = u; tlast = l;
    do begin
      tick();
      k++;
    end while (!m_acc && k < 64);
    chk("beat_accept", m_acc, 1);
    tvalid = 0; tuser = 0; tlast = 0;
  endtask

  task automatic pulse_clr();
    clr = 1;
    tick();
    clr = 0;
  endtask

  task automatic do_reset(input int cyc);
    rst_n = 0;
    repeat (cyc) tick();
    rst_n = 1;
  endtask

  int acc_cnt;

  initial begin
    do_reset(3);
    chk("rst_tready", tready, 0);
    chk("rst_fc", fc, 0);
    tick();
    chk("tready_up", tready, 1);

    // two frames, 3 lines x 4 beats, data = beat index
    cfg = 16'd4;
    for (int f = 0; f < 2; f++) begin
      for (int ln = 0; ln < 3; ln++) begin
        for (int bt = 0; bt < 4; bt++) begin
          send(W'(bt), (ln == 0 && bt == 0), (bt == 3));
          if (f == 1 && ln == 0 && bt == 0) begin
            chk("t1_fc", fc, 2);
            chk("t1_lfl", lfl, 3);
            chk("t1_fxor", fxor, 0);
          end
        end
      end
    end
    chk("t1_llb", llb, 4);
    chk("t1_noerr", {e_early, e_late, e_sof}, 0);

    // early EOL on beat 3
    send(W'(7), 0, 0);
    send(W'(8), 0, 0);
    send(W'(9), 0, 1);
    chk("early_flag", e_early, 1);
    chk("early_llb", llb, 3);
    pulse_clr();
    chk("early_clr", e_early, 0);

    // late EOL, then SOF inside the line
    for (int i = 1; i <= 5; i++) begin
      send(W'(i), 0, 0);
      if (i >= 4) chk("late_flag", e_late, 1);
    end
    send(W'(6), 1, 0);
    chk("sof_mid_flag", e_sof, 1);
    send(W'(1), 0, 1);
    pulse_clr();

    // throttle pattern 0000_0101
    cfg = 0; ten = 1; tpat = 8'b0000_0101;
    repeat (8) tick();
    acc_cnt = 0;
    tvalid = 1; tdata = W'(24'h00ab12);
    repeat (16) begin
      tick();
      if (m_acc) acc_cnt++;
    end
    tvalid = 0;
    chk("thr_accepts", acc_cnt, 4);
    ten = 0;
    repeat (2) tick();

    // one-beat lines with SOF+EOL together
    send(W'(3), 0, 1);
    pulse_clr();
    repeat (3) send(W'($urandom), 1, 1);
    chk("one_lfl", lfl, 1);
    chk("one_llb", llb, 1);
    chk("one_nosof", e_sof, 0);

    // reset mid-frame, then resume
    send(W'(5), 1, 0);
    send(W'(6), 0, 0);
    do_reset(2);
    chk("mid_rst_fc", fc, 0);
    chk("mid_rst_fxor", fxor, 0);
    tick();
    for (int ln = 0; ln < 2; ln++)
      for (int bt = 0; bt < 2; bt++)
        send(W'($urandom), (ln == 0 && bt == 0), (bt == 1));
    chk("resume_lfl0", lfl, 0);
    send(W'(1), 1, 1);
    chk("resume_lfl", lfl, 2);
    chk("resume_fc", fc, 2);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      tvalid = ($urandom_range(0, 3) != 0);
      tdata  = W'($urandom);
      tuser  = ($urandom_range(0, 15) == 0);
      tlast  = ($urandom_range(0, 4) == 0);
      clr    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 50) == 0) begin
        ten  = $urandom_range(0, 1);
        tpat = 8'($urandom);
        cfg  = 16'($urandom_range(0, 6));
      end
      tick();
    end
    tvalid = 0; tuser = 0; tlast = 0; clr = 0; ten = 0; cfg = 0;
    tick();

    // saturation on the narrow instance
    do_reset(2);
    tick();
    repeat (20) send(W'($urandom), 1, 1);
    chk("sat_fc4", fc4, 15);
    chk("sat_fc16", fc, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_video_sink_monitor.md
# axis_video_sink_monitor

Parametrised AXI4-Stream video sink that replaces the fixed always-ready stream terminator at unused or debug video outputs. It consumes every beat, with an optional programmable backpressure pattern to stress upstream IP. It measures line and frame geometry, checks SOF/EOL framing against a configured line width, and accumulates a per-frame data signature. It sits at the end of a video pipeline, and its status outputs are wired to a register block or ILA.

## Interface
Parameters:
- NUM_VIDEO_COMPONENTS, 3, components per sample
- SAMPLES_PER_CLOCK, 1, samples per beat
- MAXIMUM_DATA_WIDTH, 8, bits per component
- CNT_WIDTH, 16, width of the beat, line and frame counters
- Derived: S_AXIS_BYTES = (SAMPLES_PER_CLOCK*MAXIMUM_DATA_WIDTH*NUM_VIDEO_COMPONENTS+7)/8; S_AXIS_WIDTH = S_AXIS_BYTES*8

Ports:
- ap_clk  in  1  sole clock
- ap_rst_n  in  1  reset, synchronous, active-low
- s_axis_video_TDATA  in  S_AXIS_WIDTH  pixel data
- s_axis_video_TVALID  in  1  beat valid
- s_axis_video_TREADY  out  1  beat ready
- s_axis_video_TKEEP / TSTRB  in  S_AXIS_BYTES  ignored
- s_axis_video_TUSER  in  1  start of frame (SOF)
- s_axis_video_TLAST  in  1  end of line (EOL)
- s_axis_video_TID / TDEST  in  1  ignored
- throttle_en  in  1  0: TREADY held 1; 1: TREADY follows throttle_pattern
- throttle_pattern  in  8  ready bit per phase, LSB first
- cfg_width_beats  in  CNT_WIDTH  expected beats per line; 0 disables width checks
- clr_err  in  1  one-cycle pulse; clears the sticky error flags
- frame_count  out  CNT_WIDTH  SOFs accepted, saturating
- last_line_beats  out  CNT_WIDTH  beat count of the most recent completed line
- last_frame_lines  out  CNT_WIDTH  line count of the most recent completed frame
- frame_xor  out  S_AXIS_WIDTH  XOR of all TDATA beats of the most recent completed frame
- err_eol_early  out  1  sticky; TLAST arrived before cfg_width_beats
- err_eol_late  out  1  sticky; beat cfg_width_beats arrived without TLAST
- err_sof_mid  out  1  sticky; TUSER arrived while a line was partially received

## Operation
- Accept = TVALID & TREADY. Nothing updates on a cycle without an accept, except the throttle phase and clr_err.
- Throttle: 3-bit phase counter increments every cycle and wraps 7->0. When throttle_en=1, TREADY is registered as throttle_pattern[phase]. An all-zero pattern stalls the stream indefinitely, which is legal.
- Internal state: beat_cnt (beats of the current line), line_cnt (lines of the current frame), xor_acc, in_frame flag.
- Per accepted beat, n = TUSER ? 1 : beat_cnt+1.
- TUSER on the beat:
  - If in_frame=1, latch last_frame_lines<=line_cnt and frame_xor<=xor_acc.
  - Set xor_acc<=TDATA, line_cnt<=0, in_frame<=1, and increment frame_count.
  - If beat_cnt!=0, set err_sof_mid.
- No TUSER: xor_acc<=xor_acc^TDATA.
- TLAST on the beat:
  - last_line_beats<=n, beat_cnt<=0, line_cnt<=line_cnt+1. When TUSER is also set, this gives line_cnt=1.
  - If cfg_width_beats!=0 and n<cfg_width_beats, set err_eol_early.
- No TLAST:
  - beat_cnt<=n.
  - If cfg_width_beats!=0 and n==cfg_width_beats, set err_eol_late. The flag is set once per line, not for each further beat.
- All counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Beats accepted before the first SOF still update beat_cnt, last_line_beats and the error flags. They do not update line or frame outputs.
- clr_err clears all three flags. If clr_err coincides with a new error event, the flag ends set.

## Timing
- Reset values: TREADY=0. All counters, frame_xor, error flags, phase, in_frame and internal state = 0.
- TREADY goes to 1 on the first cycle after ap_rst_n deasserts (throttle_en=0), or to pattern[0] when throttle_en=1.
- All outputs are registered. A status update is visible on the cycle after the accepting edge, giving latency 1.
- Reset asserted mid-line or mid-frame discards all partial state. The next frame begins with in_frame=0, so no stale latch occurs.
- throttle_en changes take effect at the next registered TREADY update, one cycle later.

## Test plan
- Always-ready, cfg_width=4: 2 frames of 3 lines × 4 beats, data = beat index. Required: frame_count=2, last_line_beats=4, last_frame_lines=3 after the second SOF, frame_xor=0 for the 4-beat line pattern repeated over 3 lines, no errors.
- TLAST on beat 3 with cfg_width=4: err_eol_early=1 and last_line_beats=3. A clr_err pulse then clears it to 0 one cycle later.
- 5 beats without TLAST, cfg_width=4: err_eol_late=1 after beat 4 and stays set through beat 5. A TUSER on beat 6 sets err_sof_mid=1.
- throttle_en=1, pattern=8'b0000_0101, TVALID held high: TREADY=1 on phases 0 and 2 only. 2 beats are accepted per 8 cycles and the counters match the accepted beats only.
- One-beat lines with TUSER and TLAST on the same beat: line_cnt=1, last_line_beats=1, no err_sof_mid. Reset asserted mid-frame: all outputs return to 0, then resume correctly on the next SOF.
- CNT_WIDTH=4: 20 SOFs give frame_count=15 (saturated).
